// File: rtl/mips_cpu_muldiv.sv
// Iterative HI/LO multiply/divide unit: 32-step shift-add MULT(U), restoring DIV(U).
// Define MIPS_CPU_MULDIV_FAST_MULT_EN for a one-cycle multiplier (IDLE -> FIX -> DONE).
module mips_cpu_muldiv (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    input  logic        cancel_i,
    output logic        busy_o,
    output logic        write_enable_o,
    output logic [31:0] write_data_hi_o,
    output logic [31:0] write_data_lo_o
);
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [63:0] acc_q;
    logic [31:0] opb_q, rs_raw_q, hi_q, lo_q;
    logic        is_div_q, neg_lo_q, neg_hi_q, busy_q, we_q;

    logic        rs_neg, rt_neg;
    logic [31:0] rs_mag, rt_mag;
    logic [32:0] mul_sum_d, div_rem_d, div_diff_d;
    logic [63:0] mul_step_d, div_step_d, prod_d;
    logic [31:0] fix_hi_d, fix_lo_d;

    // op_i[0] set means unsigned
    assign rs_neg = ~op_i[0] & rs_data_i[31];
    assign rt_neg = ~op_i[0] & rt_data_i[31];
    assign rs_mag = rs_neg ? (~rs_data_i + 32'd1) : rs_data_i;
    assign rt_mag = rt_neg ? (~rt_data_i + 32'd1) : rt_data_i;

    // acc_q = {partial, multiplier} for MUL, {remainder, dividend/quotient} for DIV
    assign mul_sum_d  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    assign mul_step_d = {mul_sum_d, acc_q[31:1]};
    assign div_rem_d  = acc_q[63:31];
    assign div_diff_d = div_rem_d - {1'b0, opb_q};
    assign div_step_d = div_diff_d[32] ? {div_rem_d[31:0], acc_q[30:0], 1'b0}
                                       : {div_diff_d[31:0], acc_q[30:0], 1'b1};

    always_comb begin
        prod_d   = neg_lo_q ? (~acc_q + 64'd1) : acc_q;
        fix_hi_d = prod_d[63:32];
        fix_lo_d = prod_d[31:0];
        if (is_div_q) begin
            if (opb_q == 32'd0) begin
                fix_hi_d = rs_raw_q;
                fix_lo_d = 32'hFFFF_FFFF;
            end else begin
                fix_lo_d = neg_lo_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
                fix_hi_d = neg_hi_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            acc_q    <= 64'd0;
            opb_q    <= 32'd0;
            rs_raw_q <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            busy_q   <= 1'b0;
            we_q     <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i && !cancel_i) begin
                        busy_q   <= 1'b1;
                        cnt_q    <= 5'd0;
                        is_div_q <= op_i[1];
                        rs_raw_q <= rs_data_i;
                        neg_lo_q <= rs_neg ^ rt_neg;
                        neg_hi_q <= op_i[1] ? rs_neg : (rs_neg ^ rt_neg);
                        acc_q    <= {32'd0, op_i[1] ? rs_mag : rt_mag};
                        opb_q    <= op_i[1] ? rt_mag : rs_mag;
                        state_q  <= op_i[1] ? S_DIV : S_MUL;
`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
                        if (!op_i[1]) begin
                            acc_q   <= {32'd0, rs_mag} * {32'd0, rt_mag};
                            state_q <= S_FIX;
                        end
`endif
                    end
                end
                S_MUL, S_DIV: begin
                    if (cancel_i) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        acc_q <= (state_q == S_MUL) ? mul_step_d : div_step_d;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (cancel_i) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        hi_q    <= fix_hi_d;
                        lo_q    <= fix_lo_d;
                        we_q    <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o          = busy_q;
    assign write_enable_o  = we_q;
    assign write_data_hi_o = hi_q;
    assign write_data_lo_o = lo_q;
endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed-vector bench for mips_cpu_muldiv: results, latency, cancel, reset and start-while-busy.
module tb_mips_cpu_muldiv;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs = 32'd0, rt = 32'd0;
    logic        cancel = 1'b0;
    logic        busy, we;
    logic [31:0] hi, lo;

    int vectors = 0;
    int miscompares = 0;

`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    mips_cpu_muldiv dut (
        .clk_i(clk), .reset_i(reset_n), .start_i(start), .op_i(op),
        .rs_data_i(rs), .rt_data_i(rt), .cancel_i(cancel),
        .busy_o(busy), .write_enable_o(we),
        .write_data_hi_o(hi), .write_data_lo_o(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;

    // Starts one op and watches edges 1..40 after it; lat = edge of first write pulse.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_cyc, output int pulses);
        lat = -1; busy_cyc = 0; pulses = 0;
        @(negedge clk);
        start = 1'b1; op = o; rs = a; rt = b;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); rs = $urandom; rt = $urandom;
        for (int e = 1; e <= 40; e++) begin
            if (e > 1) begin @(posedge clk); #1; end
            if (busy) busy_cyc++;
            if (we) begin
                pulses++;
                if (lat < 0) lat = e;
            end
        end
    endtask

    task automatic test_reset();
        #3;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL reset_we got %b want 0", we); end
        vectors++; if (hi !== 32'd0) begin miscompares++; $display("FAIL reset_hi got %h want 0", hi); end
        vectors++; if (lo !== 32'd0) begin miscompares++; $display("FAIL reset_lo got %h want 0", lo); end
        @(negedge clk); reset_n = 1'b1;
    endtask

    task automatic check_table(input string name, input vec_t v[], input int exp_lat);
        int lat, bc, np;
        foreach (v[i]) begin
            run_op(v[i].op, v[i].a, v[i].b, lat, bc, np);
            vectors++; if (hi !== v[i].hi) begin miscompares++; $display("FAIL %s[%0d]_hi got %h want %h", name, i, hi, v[i].hi); end
            vectors++; if (lo !== v[i].lo) begin miscompares++; $display("FAIL %s[%0d]_lo got %h want %h", name, i, lo, v[i].lo); end
            vectors++; if (lat !== exp_lat) begin miscompares++; $display("FAIL %s[%0d]_latency got %0d want %0d", name, i, lat, exp_lat); end
            vectors++; if (bc !== exp_lat) begin miscompares++; $display("FAIL %s[%0d]_busy_cycles got %0d want %0d", name, i, bc, exp_lat); end
            vectors++; if (np !== 1) begin miscompares++; $display("FAIL %s[%0d]_pulses got %0d want 1", name, i, np); end
        end
    endtask

    task automatic test_mult();
        vec_t v[] = '{
            '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001},
            '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB},
            '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000},
            '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000},
            '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001}
        };
        check_table("mult", v, MUL_LAT);
    endtask

    task automatic test_div();
        vec_t v[] = '{
            '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD},
            '{2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF},
            '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000},
            '{2'b11, 32'hFFFF_FFFF, 32'h0000_000A, 32'h0000_0005, 32'h1999_9999},
            '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD},
            '{2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF}
        };
        check_table("div", v, DIV_LAT);
    endtask

    task automatic test_hold();
        repeat (5) @(posedge clk);
        #1;
        vectors++; if (hi !== 32'hFFFF_FFFB) begin miscompares++; $display("FAIL hold_hi got %h want fffffffb", hi); end
        vectors++; if (lo !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL hold_lo got %h want ffffffff", lo); end
    endtask

    task automatic test_cancel();
        int np = 0;
        int lat, bc;
        @(negedge clk);
        start = 1'b1; op = 2'b11; rs = 32'd1000; rt = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk); cancel = 1'b1;
        @(posedge clk); #1; cancel = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL cancel_busy got %b want 0", busy); end
        for (int e = 0; e < 40; e++) begin
            @(posedge clk); #1;
            if (we) np++;
        end
        vectors++; if (np !== 0) begin miscompares++; $display("FAIL cancel_pulses got %0d want 0", np); end
        vectors++; if (hi !== 32'hFFFF_FFFB) begin miscompares++; $display("FAIL cancel_hi_kept got %h want fffffffb", hi); end
        vectors++; if (lo !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL cancel_lo_kept got %h want ffffffff", lo); end
        run_op(2'b11, 32'd1000, 32'd3, lat, bc, np);
        vectors++; if (lo !== 32'd333 || hi !== 32'd1) begin miscompares++; $display("FAIL cancel_restart got %h/%h want 00000001/0000014d", hi, lo); end
        vectors++; if (lat !== DIV_LAT) begin miscompares++; $display("FAIL cancel_restart_latency got %0d want %0d", lat, DIV_LAT); end
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; op = 2'b01;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL cancel_with_start_busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int lat, bc, np;
        @(negedge clk);
        start = 1'b1; op = 2'b01; rs = 32'd9; rt = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0 || we !== 1'b0) begin miscompares++; $display("FAIL async_reset_ctl got busy=%b we=%b want 0/0", busy, we); end
        vectors++; if (hi !== 32'd0 || lo !== 32'd0) begin miscompares++; $display("FAIL async_reset_data got %h/%h want 0/0", hi, lo); end
        #1 reset_n = 1'b1;
        run_op(2'b01, 32'd6, 32'd7, lat, bc, np);
        vectors++; if (np !== 1) begin miscompares++; $display("FAIL reset_mid_pulses got %0d want 1", np); end
        vectors++; if (lo !== 32'd42 || hi !== 32'd0) begin miscompares++; $display("FAIL reset_mid_restart got %h/%h want 0/2a", hi, lo); end
        vectors++; if (lat !== MUL_LAT) begin miscompares++; $display("FAIL reset_mid_latency got %0d want %0d", lat, MUL_LAT); end
    endtask

    task automatic test_back_to_back();
        int np = 0, bc = 0;
        @(negedge clk);
        start = 1'b1; op = 2'b01; rs = 32'd3; rt = 32'd5;
        @(posedge clk); #1;
        op = 2'b11; rs = 32'd50; rt = 32'd7;
        if (busy) bc++;
        for (int e = 2; e <= 40; e++) begin
            @(posedge clk); #1;
            if (busy) bc++;
            if (we) np++;
            if (e == MUL_LAT + 1) start = 1'b0;
        end
        vectors++; if (np !== 1) begin miscompares++; $display("FAIL busy_start_pulses got %0d want 1", np); end
        vectors++; if (bc !== MUL_LAT) begin miscompares++; $display("FAIL busy_start_busy_cycles got %0d want %0d", bc, MUL_LAT); end
        vectors++; if (hi !== 32'd0 || lo !== 32'd15) begin miscompares++; $display("FAIL busy_start_result got %h/%h want 0/f", hi, lo); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_hold();
        test_cancel();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
